// File: rtl/ysyx_23060184_axi_arbiter_pkg.sv
// Shared types and AXI constants for the IFU/LSU bus arbiter.
// Optional feature macro used by the arbiter: ARB_ROUND_ROBIN_EN.
package ysyx_23060184_axi_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OWN_I  = 2'd1,
      ST_OWN_DR = 2'd2,
      ST_OWN_DW = 2'd3
   } arb_state_e;

   // Packed address word is {addr, id, len[7:0], size[2:0], burst[1:0]}.
   localparam int BURST_LSB    = 0;
   localparam int SIZE_LSB     = 2;
   localparam int LEN_LSB      = 5;
   localparam int ID_LSB       = 13;
   localparam int ID_WIDTH_DEF = 4;
   localparam int ADDR_LSB     = ID_LSB + ID_WIDTH_DEF;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   localparam logic [1:0] BURST_INCR = 2'b01;

   function automatic int ar_width(input int data_w, input int id_w);
      return data_w + id_w + ID_LSB;
   endfunction

endpackage

// File: rtl/ysyx_23060184_axi_arbiter_if.sv
// AXI4 channel bundle shared by the IFU, LSU and memory sides of the arbiter.
// Built the same way with or without ARB_ROUND_ROBIN_EN.
interface ysyx_23060184_axi_arbiter_if
   import ysyx_23060184_axi_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) ();

   localparam int AR_W = ar_width(DATA_WIDTH, ID_WIDTH);

   logic [AR_W-1:0]         ar;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic                    rvalid;
   logic                    rready;
   logic [AR_W-1:0]         aw;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   modport master (
      output ar, arvalid, rready, aw, awvalid, wdata, wstrb, wlast, wvalid, bready,
      input  arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  ar, arvalid, rready, aw, awvalid, wdata, wstrb, wlast, wvalid, bready,
      output arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
   );

endinterface

// File: rtl/ysyx_23060184_arb_pick.sv
// Two-way requester picker: LSU-first by default, alternating when
// ARB_ROUND_ROBIN_EN is defined. Also reports whether the LSU wants a write.
module ysyx_23060184_arb_pick (
   input  logic i_req,
   input  logic d_req,
   input  logic d_we,
   input  logic last_d,
   output logic pick_vld,
   output logic pick_d,
   output logic pick_wr
);

   logic lsu_first;

`ifdef ARB_ROUND_ROBIN_EN
   // On a tie, whoever was not served last goes first.
   assign lsu_first = !last_d;
`else
   logic unused_last_d;
   assign unused_last_d = last_d;
   assign lsu_first     = 1'b1;
`endif

   assign pick_vld = i_req || d_req;
   assign pick_d   = d_req && (!i_req || lsu_first);
   assign pick_wr  = pick_d && d_we;

endmodule

// File: rtl/ysyx_23060184_axi_arbiter.sv
// Shares the single AXI4 memory port between the IFU (read only) and LSU.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking instead of LSU priority.
module ysyx_23060184_axi_arbiter
   import ysyx_23060184_axi_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_req,
   output logic i_grant,
   input  logic d_req,
   input  logic d_we,
   output logic d_grant,
   ysyx_23060184_axi_arbiter_if.slave  ifu,
   ysyx_23060184_axi_arbiter_if.slave  lsu,
   ysyx_23060184_axi_arbiter_if.master mem
);

   localparam int AR_W = ar_width(DATA_WIDTH, ID_WIDTH);

   arb_state_e state;
   logic       last_d;
   logic       pick_vld;
   logic       pick_d;
   logic       pick_wr;

   // The IFU never writes; its write-side inputs are intentionally left unread.
   logic [AR_W-1:0]       unused_ifu_aw;
   logic [DATA_WIDTH-1:0] unused_ifu_wdata;
   logic                  unused_ifu_misc;
   assign unused_ifu_aw    = ifu.aw;
   assign unused_ifu_wdata = ifu.wdata;
   assign unused_ifu_misc  = ^{ifu.awvalid, ifu.wstrb, ifu.wlast, ifu.wvalid, ifu.bready};

`ifndef ARB_ROUND_ROBIN_EN
   assign last_d = 1'b0;
`endif

   ysyx_23060184_arb_pick u_pick (
      .i_req    (i_req),
      .d_req    (d_req),
      .d_we     (d_we),
      .last_d   (last_d),
      .pick_vld (pick_vld),
      .pick_d   (pick_d),
      .pick_wr  (pick_wr)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         i_grant <= 1'b0;
         d_grant <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d  <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  state   <= pick_d ? (pick_wr ? ST_OWN_DW : ST_OWN_DR) : ST_OWN_I;
                  i_grant <= !pick_d;
                  d_grant <= pick_d;
`ifdef ARB_ROUND_ROBIN_EN
                  last_d  <= pick_d;
`endif
               end
            end
            // rlast is the only end-of-burst marker; no beat counting here.
            ST_OWN_I, ST_OWN_DR: begin
               if (mem.rvalid && mem.rready && mem.rlast) begin
                  state   <= ST_IDLE;
                  i_grant <= 1'b0;
                  d_grant <= 1'b0;
               end
            end
            ST_OWN_DW: begin
               if (mem.bvalid && mem.bready) begin
                  state   <= ST_IDLE;
                  i_grant <= 1'b0;
                  d_grant <= 1'b0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               i_grant <= 1'b0;
               d_grant <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      ifu.arready = 1'b0;
      ifu.rdata   = '0;
      ifu.rresp   = '0;
      ifu.rlast   = 1'b0;
      ifu.rvalid  = 1'b0;
      ifu.awready = 1'b0;
      ifu.wready  = 1'b0;
      ifu.bresp   = '0;
      ifu.bvalid  = 1'b0;
      lsu.arready = 1'b0;
      lsu.rdata   = '0;
      lsu.rresp   = '0;
      lsu.rlast   = 1'b0;
      lsu.rvalid  = 1'b0;
      lsu.awready = 1'b0;
      lsu.wready  = 1'b0;
      lsu.bresp   = '0;
      lsu.bvalid  = 1'b0;
      mem.ar      = '0;
      mem.arvalid = 1'b0;
      mem.rready  = 1'b0;
      mem.aw      = '0;
      mem.awvalid = 1'b0;
      mem.wdata   = '0;
      mem.wstrb   = '0;
      mem.wlast   = 1'b0;
      mem.wvalid  = 1'b0;
      mem.bready  = 1'b0;
      case (state)
         ST_OWN_I: begin
            mem.ar      = ifu.ar;
            mem.arvalid = ifu.arvalid;
            mem.rready  = ifu.rready;
            ifu.arready = mem.arready;
            ifu.rdata   = mem.rdata;
            ifu.rresp   = mem.rresp;
            ifu.rlast   = mem.rlast;
            ifu.rvalid  = mem.rvalid;
         end
         ST_OWN_DR: begin
            mem.ar      = lsu.ar;
            mem.arvalid = lsu.arvalid;
            mem.rready  = lsu.rready;
            lsu.arready = mem.arready;
            lsu.rdata   = mem.rdata;
            lsu.rresp   = mem.rresp;
            lsu.rlast   = mem.rlast;
            lsu.rvalid  = mem.rvalid;
         end
         ST_OWN_DW: begin
            mem.aw      = lsu.aw;
            mem.awvalid = lsu.awvalid;
            mem.wdata   = lsu.wdata;
            mem.wstrb   = lsu.wstrb;
            mem.wlast   = lsu.wlast;
            mem.wvalid  = lsu.wvalid;
            mem.bready  = lsu.bready;
            lsu.awready = mem.awready;
            lsu.wready  = mem.wready;
            lsu.bresp   = mem.bresp;
            lsu.bvalid  = mem.bvalid;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/ysyx_23060184_axi_arbiter.md
Name: ysyx_23060184_axi_arbiter

Overview:
- Shares the single AXI4 master port to memory between two requesters: the instruction fetch unit (IFU, read only) and the load/store unit (LSU, read and write).
- Grants one requester at a time and holds ownership for the whole burst.
- Muxes AR/AW/W from the owner to the bus and routes R/B back to the owner.
- Sits between the IFU/LSU front ends and the SoC crossbar; it produces the IFU's `grant` input.

Parameters:
- DATA_WIDTH, 32, address/data width
- ID_WIDTH, 4, AXI ID width
- AR_W, DATA_WIDTH+ID_WIDTH+8+3+2, packed {addr,id,len,size,burst} width; same packing for AW

Ports:
- clk  in  1  clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- i_req  in  1  IFU bus request (the IFU's Irequest)
- i_grant  out  1  IFU owns the bus
- i_ar  in  AR_W  IFU packed read address
- i_arvalid  in  1  IFU AR valid
- i_arready  out  1  IFU AR ready
- i_rdata/i_rresp/i_rlast/i_rvalid  out  DATA_WIDTH/2/1/1  R channel to IFU
- i_rready  in  1  IFU R ready
- d_req  in  1  LSU bus request
- d_we  in  1  LSU request is a write; sampled with d_req
- d_grant  out  1  LSU owns the bus
- d_ar/d_arvalid/d_arready  in/in/out  AR_W/1/1  LSU AR channel
- d_rdata/d_rresp/d_rlast/d_rvalid/d_rready  out/out/out/out/in  DATA_WIDTH/2/1/1/1  LSU R channel
- d_aw/d_awvalid/d_awready  in/in/out  AR_W/1/1  LSU AW channel
- d_wdata/d_wstrb/d_wlast/d_wvalid/d_wready  in/in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1/1  LSU W channel
- d_bresp/d_bvalid/d_bready  out/out/in  2/1/1  LSU B channel
- m_*  mirror set  —  bus-side AR, R, AW, W, B (m_ar, m_arvalid, m_arready, ..., m_bready), same widths, opposite directions

Behaviour:
- FSM states: IDLE, OWN_I, OWN_DR, OWN_DW. Reset puts the FSM in IDLE.
- Reset values: all grants 0; all m_* valid/ready outputs 0; all requester-side ready/valid outputs 0. Payload outputs are don't-care but must be driven 0.
- IDLE arbitration:
  - both requests → LSU wins (fixed priority, default build), because the LSU stalls the pipeline.
  - d_req&d_we → OWN_DW; d_req&!d_we → OWN_DR; else i_req → OWN_I.
- Grant latency: registered, asserted the cycle after the request is sampled in IDLE. Grant is held continuously while in an OWN_* state.
- Request rules:
  - a request dropped before it is granted is withdrawn with no side effect.
  - while granted, the request level is ignored.
- Channel routing in OWN_I/OWN_DR:
  - owner's AR and R are connected combinationally to m_AR and m_R; no added latency.
  - non-owner sees arready=0 and rvalid=0.
  - m_aw/m_w valids are 0.
- Channel routing in OWN_DW:
  - LSU AW/W/B are connected to m_; m_arvalid=0 and m_rready=0.
  - IFU arready=0 and rvalid=0.
- Release:
  - OWN_I/OWN_DR → IDLE on the owner's m_rvalid&m_rready&m_rlast.
  - OWN_DW → IDLE on m_bvalid&m_bready.
  - Grant deasserts in the cycle after the release handshake.
  - IDLE lasts a minimum of one cycle, so back-to-back owners always have a one-cycle gap.
- Error responses: rresp/bresp ≠ OKAY are passed through unmodified. Release still occurs on the last beat or the B handshake. The arbiter does not abort or retry.
- Beat count: no internal beat counter; rlast is authoritative. Bursts of any arlen, up to 256 beats, are supported.
- Reset asserted mid-burst: immediate return to IDLE, all valids/readies drop asynchronously. Bus-side cleanup is the slave's responsibility under the shared reset.
- Illegal inputs: a valid asserted by a non-owner is ignored and never reaches m_*.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - a 1-bit last-owner register (reset: IFU) selects the winner in IDLE when both request; the requester not served last wins.
  - LSU read vs write is still chosen by d_we.
- Undefined: fixed LSU priority as above. The IFU can starve under continuous LSU traffic; this is accepted.

Decomposition:
- Shared package holds:
  - FSM state enum.
  - AR_W packing offsets (ADDR_LSB, ID_LSB, LEN_LSB, SIZE_LSB, BURST_LSB).
  - AXI RESP constants OKAY/EXOKAY/SLVERR/DECERR.
  - BURST_INCR.
- One sub-module, ysyx_23060184_arb_pick: combinational 2-way picker (fixed or round-robin under the macro) returning the winner and a rd/wr flag.
- Muxing stays in the top level.

Test Plan:
- i_req=1 alone, arlen=3 → i_grant high from cycle 1; 4 R beats routed to IFU; i_grant low the cycle after the rlast handshake; d_rvalid stays 0 throughout.
- i_req and d_req (d_we=0) asserted in the same cycle, default build → d_grant first; IFU granted after the LSU rlast plus one IDLE cycle.
- Same stimulus with ARB_ROUND_ROBIN_EN, repeated 4 times → grants alternate LSU, IFU, LSU, IFU.
- d_req, d_we=1, single beat, m_bresp=SLVERR → d_bresp=2'b10 delivered; release on the B handshake; m_arvalid stays 0 during ownership.
- IFU granted, rstn pulsed low mid-burst after beat 2 of 4 → i_grant, m_arvalid and m_rready drop to 0 asynchronously; after reset, FSM is in IDLE and accepts a new i_req normally.
- d_req pulsed for 1 cycle while the IFU owns the bus → no LSU grant ever issued; IFU burst unaffected.
